// File: rtl/pipe_sum_tree.sv
// rtl/pipe_sum_tree.sv - pipelined signed adder-tree reducer with saturating dot-product accumulator
module pipe_sum_tree #(
    parameter int WORD_LEN   = 32,
    parameter int MATRIX_DIM = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_in,
    input  logic                           last_in,
    input  logic                           mode_in,
    input  logic [WORD_LEN*MATRIX_DIM-1:0] In_1,
    output logic                           we_out,
    output logic [WORD_LEN-1:0]            sum_out,
    output logic                           ovf_out,
    output logic                           busy
);

    localparam int STAGES = $clog2(MATRIX_DIM);
    // Tree nodes stored heap-style, level by level: the MATRIX_DIM registered
    // input lanes first, then MATRIX_DIM/2 stage-0 sums, ... down to the root.
    localparam int NODES  = 2 * MATRIX_DIM - 1;
    localparam int ROOT   = NODES - 1;

    // Pair add at WORD_LEN+1 bits; returns {clamped, result}.
    // SCALE keeps the upper WORD_LEN bits (floor halve), SAT clamps.
    function automatic logic [WORD_LEN:0] add_pair(
        input logic [WORD_LEN-1:0] a,
        input logic [WORD_LEN-1:0] b,
        input logic                sat
    );
        logic [WORD_LEN:0] s;
        s = {a[WORD_LEN-1], a} + {b[WORD_LEN-1], b};
        if (!sat) begin
            return {1'b0, s[WORD_LEN:1]};
        end
        if (s[WORD_LEN] != s[WORD_LEN-1]) begin
            return {1'b1, s[WORD_LEN], {(WORD_LEN-1){~s[WORD_LEN]}}};
        end
        return {1'b0, s[WORD_LEN-1:0]};
    endfunction

    logic [WORD_LEN-1:0] node_q [NODES];
    logic [WORD_LEN-1:0] node_d [NODES];
    logic [STAGES:0]     vld_q, vld_d;
    logic [STAGES:0]     last_q, last_d;
    logic [STAGES:0]     ovf_q, ovf_d;
    logic [STAGES-1:0]   mode_q, mode_d;
    logic [WORD_LEN:0]   pair_res;
    logic                lane_ovf;

    logic [WORD_LEN-1:0] acc_q, acc_d;
    logic                sticky_q, sticky_d;
    logic                busy_q, busy_d;
    logic                we_out_q, we_out_d;
    logic [WORD_LEN-1:0] sum_out_q, sum_out_d;
    logic                ovf_out_q, ovf_out_d;
    logic [WORD_LEN:0]   acc_res;
    logic [WORD_LEN-1:0] new_acc;
    logic                new_ovf;

    // Tree datapath: data nodes load on their beat's valid, flags shift every cycle.
    always_comb begin
        node_d   = node_q;
        mode_d   = mode_q;
        ovf_d    = '0;
        pair_res = '0;
        lane_ovf = 1'b0;
        vld_d    = {vld_q[STAGES-1:0], we_in};
        last_d   = {last_q[STAGES-1:0], we_in & last_in};
        mode_d[0] = mode_in;
        for (int l = 1; l < STAGES; l++) begin
            mode_d[l] = mode_q[l-1];
        end
        if (we_in) begin
            for (int i = 0; i < MATRIX_DIM; i++) begin
                node_d[i] = In_1[i*WORD_LEN +: WORD_LEN];
            end
        end
        for (int l = 1; l <= STAGES; l++) begin
            lane_ovf = 1'b0;
            for (int j = 0; j < (MATRIX_DIM >> l); j++) begin
                pair_res = add_pair(node_q[2*MATRIX_DIM - 2*(MATRIX_DIM >> (l-1)) + 2*j],
                                    node_q[2*MATRIX_DIM - 2*(MATRIX_DIM >> (l-1)) + 2*j + 1],
                                    mode_q[l-1]);
                lane_ovf = lane_ovf | pair_res[WORD_LEN];
                if (vld_q[l-1]) begin
                    node_d[2*MATRIX_DIM - 2*(MATRIX_DIM >> l) + j] = pair_res[WORD_LEN-1:0];
                end
            end
            ovf_d[l] = ovf_q[l-1] | lane_ovf;
        end
    end

    // Accumulator: first beat loads, later beats add with saturation; last beat publishes and clears.
    always_comb begin
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        busy_d    = busy_q;
        we_out_d  = 1'b0;
        sum_out_d = sum_out_q;
        ovf_out_d = ovf_out_q;
        acc_res   = add_pair(acc_q, node_q[ROOT], 1'b1);
        new_acc   = busy_q ? acc_res[WORD_LEN-1:0] : node_q[ROOT];
        new_ovf   = ovf_q[STAGES] | (busy_q & (sticky_q | acc_res[WORD_LEN]));
        if (vld_q[STAGES]) begin
            if (last_q[STAGES]) begin
                sum_out_d = new_acc;
                ovf_out_d = new_ovf;
                we_out_d  = 1'b1;
                acc_d     = '0;
                sticky_d  = 1'b0;
                busy_d    = 1'b0;
            end else begin
                acc_d    = new_acc;
                sticky_d = new_ovf;
                busy_d   = 1'b1;
            end
        end
    end

    // State registers; reset discards in-flight beats and any partial dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                node_q[i] <= '0;
            end
            vld_q     <= '0;
            last_q    <= '0;
            ovf_q     <= '0;
            mode_q    <= '0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            busy_q    <= 1'b0;
            we_out_q  <= 1'b0;
            sum_out_q <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            node_q    <= node_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            busy_q    <= busy_d;
            we_out_q  <= we_out_d;
            sum_out_q <= sum_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign we_out  = we_out_q;
    assign sum_out = sum_out_q;
    assign ovf_out = ovf_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pipe_sum_tree.sv
// tb/tb_pipe_sum_tree.sv - self-checking bench for pipe_sum_tree
module tb_pipe_sum_tree;

    localparam int W      = 32;
    localparam int M      = 8;
    localparam int STAGES = 3;
    localparam int LAT    = STAGES + 1;
    localparam int NCYC   = 4096;
    localparam longint MAXV = (longint'(1) << (W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (W-1));

    typedef struct {
        logic [W*M-1:0] lanes;
        logic           mode;
        logic [W-1:0]   exp_sum;
        logic           exp_ovf;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           we_in;
    logic           last_in;
    logic           mode_in;
    logic [W*M-1:0] in_1;
    logic           we_out;
    logic [W-1:0]   sum_out;
    logic           ovf_out;
    logic           busy;

    pipe_sum_tree #(.WORD_LEN(W), .MATRIX_DIM(M)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_in   (we_in),
        .last_in (last_in),
        .mode_in (mode_in),
        .In_1    (in_1),
        .we_out  (we_out),
        .sum_out (sum_out),
        .ovf_out (ovf_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;

    bit           sched_set  [NCYC];
    bit           sched_we   [NCYC];
    bit           sched_busy [NCYC];
    bit           sched_ovf  [NCYC];
    logic [W-1:0] sched_sum  [NCYC];
    bit           cur_busy;
    logic [W-1:0] cur_sum;
    longint       m_acc;
    bit           m_ovf;
    bit           m_busy;
    vec_t         vecs [9];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        else passed++;
    endtask

    function automatic logic [W*M-1:0] rep(input logic [W-1:0] v);
        logic [W*M-1:0] r;
        for (int i = 0; i < M; i++) r[i*W +: W] = v;
        return r;
    endfunction

    // Reference: reduce level by level with plain integer arithmetic.
    task automatic model_tree(input logic [W*M-1:0] lanes, input bit mode,
                              output longint res, output bit ovf);
        longint v [M];
        longint s;
        int n;
        ovf = 0;
        for (int i = 0; i < M; i++) v[i] = longint'($signed(lanes[i*W +: W]));
        n = M;
        while (n > 1) begin
            for (int j = 0; j < n / 2; j++) begin
                s = v[2*j] + v[2*j+1];
                if (mode) begin
                    if (s > MAXV) begin s = MAXV; ovf = 1; end
                    else if (s < MINV) begin s = MINV; ovf = 1; end
                end else begin
                    s = s >>> 1;
                end
                v[j] = s;
            end
            n = n / 2;
        end
        res = v[0];
    endtask

    task automatic check_now();
        bit exp_we;
        exp_we = sched_set[cyc] && sched_we[cyc];
        if (sched_set[cyc]) begin
            cur_busy = sched_busy[cyc];
            if (sched_we[cyc]) cur_sum = sched_sum[cyc];
        end
        cmp("we_out", 64'(we_out), 64'(exp_we));
        cmp("busy", 64'(busy), 64'(cur_busy));
        cmp("sum_out", 64'(sum_out), 64'(cur_sum));
        if (exp_we) cmp("ovf_out", 64'(ovf_out), 64'(sched_ovf[cyc]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_now();
    endtask

    task automatic idle(input int n);
        we_in   = 1'b0;
        last_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive_beat(input logic [W*M-1:0] lanes, input bit mode, input bit last,
                              input bit use_exp, input logic [W-1:0] es, input bit eo);
        longint t, a;
        bit tov, o, clp;
        int idx;
        we_in   = 1'b1;
        in_1    = lanes;
        mode_in = mode;
        last_in = last;
        model_tree(lanes, mode, t, tov);
        clp = 0;
        if (!m_busy) begin
            a = t;
            o = tov;
        end else begin
            a = m_acc + t;
            if (a > MAXV) begin a = MAXV; clp = 1; end
            else if (a < MINV) begin a = MINV; clp = 1; end
            o = m_ovf | tov | clp;
        end
        idx = cyc + 1 + LAT;
        sched_set[idx] = 1;
        sched_we[idx]  = last;
        if (last) begin
            sched_sum[idx]  = use_exp ? es : a[W-1:0];
            sched_ovf[idx]  = use_exp ? eo : o;
            sched_busy[idx] = 0;
            m_busy = 0;
            m_acc  = 0;
            m_ovf  = 0;
        end else begin
            sched_busy[idx] = 1;
            m_busy = 1;
            m_acc  = a;
            m_ovf  = o;
        end
        tick();
    endtask

    task automatic reset_dut(input int n, input bit chk_now);
        rst_n = 1'b0;
        we_in = 1'b0;
        if (chk_now) begin
            #1;
            cmp("rst_we_out", 64'(we_out), 64'd0);
            cmp("rst_sum_out", 64'(sum_out), 64'd0);
            cmp("rst_ovf_out", 64'(ovf_out), 64'd0);
            cmp("rst_busy", 64'(busy), 64'd0);
        end
        m_acc = 0; m_ovf = 0; m_busy = 0;
        cur_busy = 0;
        cur_sum  = '0;
        for (int i = cyc + 1; i < NCYC; i++) begin
            sched_set[i] = 0;
            sched_we[i]  = 0;
        end
        repeat (n) begin
            we_in   = 1'($urandom);
            last_in = 1'($urandom);
            mode_in = 1'($urandom);
            for (int i = 0; i < M; i++) in_1[i*W +: W] = $urandom;
            tick();
            cmp("rst_ovf_out", 64'(ovf_out), 64'd0);
        end
        we_in   = 1'b0;
        last_in = 1'b0;
        rst_n   = 1'b1;
    endtask

    function automatic logic [W*M-1:0] rand_lanes();
        logic [W*M-1:0] r;
        for (int i = 0; i < M; i++) begin
            case ($urandom_range(2))
                0:       r[i*W +: W] = $urandom;
                1:       r[i*W +: W] = W'($urandom_range(200)) - W'(100);
                default: r[i*W +: W] = $urandom_range(1) ? 32'h7FFF_FFF0 + W'($urandom_range(15))
                                                         : 32'h8000_0000 + W'($urandom_range(15));
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [W*M-1:0] l;
        rst_n   = 1'b0;
        we_in   = 1'b0;
        last_in = 1'b0;
        mode_in = 1'b0;
        in_1    = '0;
        cur_busy = 0;
        cur_sum  = '0;
        m_acc = 0; m_ovf = 0; m_busy = 0;

        for (int i = 0; i < M; i++) l[i*W +: W] = W'(i + 1);
        vecs[0] = '{l, 1'b0, 32'd4, 1'b0};
        vecs[6] = '{l, 1'b1, 32'd36, 1'b0};
        for (int i = 0; i < M; i++) l[i*W +: W] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
        vecs[1] = '{l, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{rep(32'h7FFF_FFFF), 1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[3] = '{rep(32'h8000_0000), 1'b1, 32'h8000_0000, 1'b1};
        vecs[4] = '{rep(32'h7FFF_FFFF), 1'b0, 32'h7FFF_FFFF, 1'b0};
        vecs[5] = '{rep(32'h8000_0000), 1'b0, 32'h8000_0000, 1'b0};
        vecs[7] = '{rep(32'hFFFF_FFFF), 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{rep(32'd1), 1'b0, 32'd1, 1'b0};

        reset_dut(3, 1'b0);
        idle(10);

        for (int v = 0; v < 9; v++) begin
            drive_beat(vecs[v].lanes, vecs[v].mode, 1'b1, 1'b1, vecs[v].exp_sum, vecs[v].exp_ovf);
            idle(5);
        end

        drive_beat(rep(32'd1), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        drive_beat(rep(32'd1), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        drive_beat(rep(32'd1), 1'b1, 1'b1, 1'b1, 32'd24, 1'b0);
        idle(6);

        drive_beat(rep(32'h7FFF_FFFF), 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
        for (int k = 1; k <= 5; k++)
            drive_beat(rep(W'(k)), 1'b1, 1'b1, 1'b1, W'(8 * k), 1'b0);
        idle(6);

        drive_beat(rep(32'd5), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        drive_beat(rep(32'd5), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        reset_dut(1, 1'b1);
        drive_beat(rep(32'd2), 1'b1, 1'b1, 1'b1, 32'd16, 1'b0);
        idle(6);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) != 0) begin
                drive_beat(rand_lanes(), 1'($urandom), $urandom_range(3) == 0, 1'b0, '0, 1'b0);
            end else begin
                we_in   = 1'b0;
                last_in = 1'($urandom);
                mode_in = 1'($urandom);
                in_1    = rand_lanes();
                tick();
            end
        end
        drive_beat(rand_lanes(), 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
